// File: rtl/spi_mosi_rx.sv
// SPI MOSI receiver: LSB-first serial-to-parallel shifter
// feeding a show-ahead receive FIFO with overflow and frame error flags.
module spi_mosi_rx #(
    parameter int DSIZE = 8,
    parameter int DEPTH = 4
) (
    input  logic                     spi_clk,
    input  logic                     spi_rst_n,
    input  logic                     spi_cs,
    input  logic                     spi_mosi_in,
    input  logic                     rd_en,
    output logic [DSIZE-1:0]         rx_data,
    output logic                     data_av,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     overflow,
    output logic                     frame_err
);

    localparam int CW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [CW-1:0] LAST_BIT = CW'(DSIZE - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [CW-1:0]      bit_cnt;
    logic [DSIZE-2:0]   shreg;

    logic [DSIZE-1:0]   mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    logic               push;
    logic [DSIZE-1:0]   push_word;
    logic               pop;
    logic               wr_ok;

    // Final bit of a word completes it on the same edge it is sampled.
    always_comb begin
        push      = !spi_cs && (bit_cnt == LAST_BIT);
        push_word = {spi_mosi_in, shreg};
    end

    // Pop only when a word is present; a push into a full FIFO
    // is only accepted when a pop frees a slot on the same edge.
    always_comb begin
        pop   = rd_en && data_av;
        wr_ok = push && (!fifo_full || pop);
    end

    // Status outputs derived from the registered level.
    always_comb begin
        data_av   = (rx_level != '0);
        fifo_full = (rx_level == FULL_LVL);
        rx_data   = mem[rd_ptr];
    end

    // Serial-side FSM: bit counter, shift register and frame error pulse.
    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (spi_cs) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                shreg     <= '0;
                frame_err <= (state == SHIFT) && (bit_cnt != '0);
            end else begin
                state <= SHIFT;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    shreg   <= '0;
                end else begin
                    bit_cnt        <= bit_cnt + 1'b1;
                    shreg[bit_cnt] <= spi_mosi_in;
                end
            end
        end
    end

    // Receive FIFO storage and write pointer.
    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (wr_ok) begin
            mem[wr_ptr] <= push_word;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on every accepted pop.
    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy tracks accepted pushes minus pops.
    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            rx_level <= '0;
        end else begin
            unique case ({wr_ok, pop})
                2'b10:   rx_level <= rx_level + 1'b1;
                2'b01:   rx_level <= rx_level - 1'b1;
                default: rx_level <= rx_level;
            endcase
        end
    end

    // Sticky drop indicator, cleared only by reset.
    always_ff @(posedge spi_clk or negedge spi_rst_n) begin
        if (!spi_rst_n) begin
            overflow <= 1'b0;
        end else if (push && !wr_ok) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_mosi_rx.sv
// Testbench for spi_mosi_rx: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based word model.
module tb_spi_mosi_rx;

    localparam int DSIZE = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             spi_cs;
    logic             spi_mosi_in;
    logic             rd_en;
    logic [DSIZE-1:0] rx_data;
    logic             data_av;
    logic             fifo_full;
    logic [2:0]       rx_level;
    logic             overflow;
    logic             frame_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_q[$];
    int         m_nb;
    logic [7:0] m_acc;
    logic       m_ovf;
    logic       m_ferr;

    spi_mosi_rx #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
        .spi_clk     (clk),
        .spi_rst_n   (rst_n),
        .spi_cs      (spi_cs),
        .spi_mosi_in (spi_mosi_in),
        .rd_en       (rd_en),
        .rx_data     (rx_data),
        .data_av     (data_av),
        .fifo_full   (fifo_full),
        .rx_level    (rx_level),
        .overflow    (overflow),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_nb   = 0;
        m_acc  = '0;
        m_ovf  = 1'b0;
        m_ferr = 1'b0;
    endtask

    // One clock edge of the word-level model.
    task automatic model_edge(input logic cs, input logic mosi,
                              input logic rd);
        int         pre;
        logic       do_pop;
        logic       do_push;
        logic [7:0] word;
        pre     = m_q.size();
        do_pop  = rd && (pre != 0);
        do_push = 1'b0;
        word    = '0;
        m_ferr  = 1'b0;
        if (!cs) begin
            m_acc[m_nb] = mosi;
            m_nb++;
            if (m_nb == DSIZE) begin
                word  = m_acc;
                m_nb  = 0;
                m_acc = '0;
                if (pre == DEPTH && !do_pop) m_ovf = 1'b1;
                else do_push = 1'b1;
            end
        end else begin
            m_ferr = (m_nb != 0);
            m_nb   = 0;
            m_acc  = '0;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(word);
    endtask

    task automatic check_all();
        check("level", 32'(rx_level), 32'(m_q.size()));
        check("data_av", 32'(data_av), 32'(m_q.size() != 0));
        check("full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
        if (m_q.size() != 0) check("rx_data", 32'(rx_data), 32'(m_q[0]));
    endtask

    task automatic step(input logic cs, input logic mosi, input logic rd);
        @(negedge clk);
        spi_cs      = cs;
        spi_mosi_in = mosi;
        rd_en       = rd;
        @(posedge clk);
        model_edge(cs, mosi, rd);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [7:0] w, input logic rd_last);
        for (int i = 0; i < DSIZE; i++) begin
            step(1'b0, w[i], (i == DSIZE - 1) ? rd_last : 1'b0);
        end
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, 32'(rx_data), 32'(exp));
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic reset_now();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_level", 32'(rx_level), 32'd0);
        check("rst_av", 32'(data_av), 32'd0);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        spi_cs = 1'b1;
        rd_en  = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        rst_n       = 1'b0;
        spi_cs      = 1'b1;
        spi_mosi_in = 1'b0;
        rd_en       = 1'b0;
        model_reset();
        #12;
        check("init_level", 32'(rx_level), 32'd0);
        check("init_av", 32'(data_av), 32'd0);
        check("init_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single word
        send_word(8'hA5, 1'b0);
        check("single_av", 32'(data_av), 32'd1);
        check("single_data", 32'(rx_data), 32'hA5);
        check("single_level", 32'(rx_level), 32'd1);
        pop_expect("single_pop", 8'hA5);

        // back-to-back
        send_word(8'h3C, 1'b0);
        send_word(8'hF0, 1'b0);
        check("b2b_level", 32'(rx_level), 32'd2);
        check("b2b_head", 32'(rx_data), 32'h3C);
        step(1'b1, 1'b0, 1'b1);
        check("b2b_pop_data", 32'(rx_data), 32'hF0);
        check("b2b_pop_level", 32'(rx_level), 32'd1);
        pop_expect("b2b_last", 8'hF0);
        step(1'b1, 1'b0, 1'b1);
        check("empty_rd_level", 32'(rx_level), 32'd0);

        // partial frame
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("partial_ferr", 32'(frame_err), 32'd1);
        check("partial_level", 32'(rx_level), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("partial_ferr_end", 32'(frame_err), 32'd0);
        send_word(8'h81, 1'b0);
        check("after_partial", 32'(rx_data), 32'h81);
        pop_expect("after_partial_pop", 8'h81);

        // overflow
        for (int i = 1; i <= 5; i++) send_word(8'(i), 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int i = 1; i <= 4; i++) pop_expect("ovf_pop", 8'(i));
        check("ovf_empty", 32'(data_av), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // full with simultaneous pop
        reset_now();
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        send_word(8'h33, 1'b0);
        send_word(8'h44, 1'b0);
        send_word(8'h77, 1'b1);
        check("fullpop_ovf", 32'(overflow), 32'd0);
        check("fullpop_level", 32'(rx_level), 32'd4);
        pop_expect("fullpop_1", 8'h22);
        pop_expect("fullpop_2", 8'h33);
        pop_expect("fullpop_3", 8'h44);
        pop_expect("fullpop_last", 8'h77);
        check("fullpop_empty", 32'(data_av), 32'd0);

        // reset mid-operation
        send_word(8'hC3, 1'b0);
        send_word(8'h18, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        reset_now();
        step(1'b1, 1'b0, 1'b0);
        check("rst_no_ferr", 32'(frame_err), 32'd0);
        send_word(8'h5A, 1'b0);
        check("rst_next", 32'(rx_data), 32'h5A);
        check("rst_next_level", 32'(rx_level), 32'd1);

        // random traffic
        reset_now();
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 19) == 0, 1'($urandom),
                 $urandom_range(0, 9) < 3);
        end
        for (int n = 0; n < 6; n++) step(1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
